// File: rtl/pt_credit_tx.sv
// Credit-based transmitter: forwards items only while remote buffer credits remain.
// Optional macro PT_CREDIT_TX_CHECK_EN enables the sticky credit-overflow flag on o_error.
module pt_credit_tx #(
  parameter type DATA_T = logic [31:0],
  parameter int  DEPTH  = 8
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  DATA_T                        i_data,
  input  logic                         i_valid,
  output logic                         o_ready,
  output DATA_T                        o_tx_data,
  output logic                         o_tx_valid,
  input  logic                         i_crd_return,
  output logic [$clog2(DEPTH+1)-1:0]   o_credits,
  output logic [1:0]                   o_state,
  output logic                         o_idle,
  output logic                         o_error
);

  localparam int COUNT_W = $clog2(DEPTH+1);
  localparam logic [COUNT_W-1:0] DEPTH_C = COUNT_W'(DEPTH);
  localparam logic [COUNT_W-1:0] ONE_C   = COUNT_W'(1);

  typedef enum logic [1:0] {
    ST_FULL    = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_EMPTY   = 2'd2
  } state_e;

  logic [COUNT_W-1:0] credits_q, credits_d;
  state_e             state_q, state_d;
  DATA_T              tx_data_q, tx_data_d;
  logic               tx_valid_q, tx_valid_d;
  logic               send;

  // Handshake: an item transfers when i_valid && o_ready; o_ready depends only on
  // registered credits, so a credit returned this cycle is usable from the next one.
  assign o_ready = (credits_q != '0);
  assign send    = i_valid && o_ready;

  always_comb begin
    credits_d = credits_q;
    if (send && !i_crd_return) begin
      credits_d = credits_q - ONE_C;
    end else if (!send && i_crd_return && (credits_q != DEPTH_C)) begin
      credits_d = credits_q + ONE_C;
    end

    state_d = ST_PARTIAL;
    if (credits_d == DEPTH_C) begin
      state_d = ST_FULL;
    end else if (credits_d == '0) begin
      state_d = ST_EMPTY;
    end

    tx_valid_d = send;
    tx_data_d  = send ? i_data : tx_data_q;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      credits_q  <= DEPTH_C;
      state_q    <= ST_FULL;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      credits_q  <= credits_d;
      state_q    <= state_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
    end
  end

`ifdef PT_CREDIT_TX_CHECK_EN
  logic error_q, error_d;

  always_comb begin
    error_d = error_q;
    if (i_crd_return && !send && (credits_q == DEPTH_C)) begin
      error_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      error_q <= 1'b0;
    end else begin
      error_q <= error_d;
    end
  end

  assign o_error = error_q;
`else
  assign o_error = 1'b0;
`endif

  assign o_tx_data  = tx_data_q;
  assign o_tx_valid = tx_valid_q;
  assign o_credits  = credits_q;
  assign o_state    = state_q;
  assign o_idle     = (state_q == ST_FULL);

  // Every transition between the three encodings is legal, so the only illegal
  // observations are the unused encoding or a state inconsistent with the count.
  always @(posedge i_clk) begin
    if (i_rst) begin
      assert (state_q != 2'd3);
      assert (credits_q <= DEPTH_C);
      assert ((state_q == ST_FULL) == (credits_q == DEPTH_C));
      assert ((state_q == ST_EMPTY) == (credits_q == '0));
    end
  end

endmodule

// File: tb/tb_pt_credit_tx.sv
// Directed plus random bench for pt_credit_tx (DEPTH=4) with an expected-data scoreboard.
module tb_pt_credit_tx;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);

  logic          clk;
  logic          rst_n;
  logic [31:0]   i_data;
  logic          i_valid;
  logic          o_ready;
  logic [31:0]   o_tx_data;
  logic          o_tx_valid;
  logic          i_crd_return;
  logic [CW-1:0] o_credits;
  logic [1:0]    o_state;
  logic          o_idle;
  logic          o_error;

  pt_credit_tx #(.DATA_T(logic [31:0]), .DEPTH(DEPTH)) dut (
    .i_clk        (clk),
    .i_rst        (rst_n),
    .i_data       (i_data),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .o_tx_data    (o_tx_data),
    .o_tx_valid   (o_tx_valid),
    .i_crd_return (i_crd_return),
    .o_credits    (o_credits),
    .o_state      (o_state),
    .o_idle       (o_idle),
    .o_error      (o_error)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef PT_CREDIT_TX_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic [31:0] exp_q[$];
  int          pass_cnt  = 0;
  int          total_cnt = 0;
  int          m_cred;
  logic        m_err;
  int          rx_occ;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [1:0] model_state(input int c);
    if (c == DEPTH) return 2'd0;
    if (c == 0)     return 2'd2;
    return 2'd1;
  endfunction

  // scoreboard: each DUT output strobe pops the oldest expected item
  always @(negedge clk) begin
    if (o_tx_valid) begin
      if (exp_q.size() == 0) begin
        check("tx_unexpected", 32'd1, 32'd0);
      end else begin
        check("tx_data", o_tx_data, exp_q.pop_front());
      end
    end
  end

  // driver: one clock cycle with the given inputs, then check registered outputs
  task automatic cycle(input logic v, input logic r, input logic [31:0] d);
    logic m_send;
    i_valid      = v;
    i_crd_return = r;
    i_data       = d;
    if (rst_n) check("ready", {31'd0, o_ready}, {31'd0, (m_cred != 0)});
    m_send = rst_n && v && (m_cred != 0);
    if (!rst_n) begin
      m_cred = DEPTH;
      m_err  = 1'b0;
    end else begin
      if (m_send) exp_q.push_back(d);
      if (m_send && !r) m_cred--;
      else if (!m_send && r) begin
        if (m_cred == DEPTH) m_err = m_err | CHECK_EN;
        else m_cred++;
      end
    end
    @(posedge clk);
    #1;
    check("tx_valid", {31'd0, o_tx_valid}, {31'd0, m_send});
    check("credits",  {{(32-CW){1'b0}}, o_credits}, 32'(m_cred));
    check("state",    {30'd0, o_state}, {30'd0, model_state(m_cred)});
    check("idle",     {31'd0, o_idle}, {31'd0, (m_cred == DEPTH)});
    check("error",    {31'd0, o_error}, {31'd0, m_err});
  endtask

  initial begin
    rst_n        = 1'b0;
    i_valid      = 1'b0;
    i_crd_return = 1'b0;
    i_data       = '0;
    m_cred       = DEPTH;
    m_err        = 1'b0;
    rx_occ       = 0;

    // reset with inputs asserted: they must be ignored
    cycle(1'b1, 1'b1, 32'hdead_beef);
    cycle(1'b1, 1'b1, 32'hdead_beef);
    check("rst_tx_data", o_tx_data, 32'd0);
    rst_n = 1'b1;

    // four back-to-back sends drain all credits, fifth is blocked
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 32'h1000 + 32'(i));

    // return at zero credits: no send that cycle, send the next
    cycle(1'b1, 1'b1, 32'h2000);
    cycle(1'b1, 1'b0, 32'h2001);

    // climb to 2 credits, then send and return together
    cycle(1'b0, 1'b1, 32'h0);
    cycle(1'b0, 1'b1, 32'h0);
    cycle(1'b1, 1'b1, 32'h3000);

    // back to full, then an excess return is dropped
    cycle(1'b0, 1'b1, 32'h0);
    cycle(1'b0, 1'b1, 32'h0);
    cycle(1'b0, 1'b1, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);

    // down to one credit, then reset mid-operation
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'h4000 + 32'(i));
    rst_n = 1'b0;
    cycle(1'b1, 1'b1, 32'h5000);
    rst_n = 1'b1;
    cycle(1'b1, 1'b0, 32'h5001);

    // random traffic against a remote FIFO model that only returns what it holds
    rx_occ = DEPTH - m_cred;
    for (int i = 0; i < 300; i++) begin
      logic v, r, s;
      v = ($urandom_range(0, 3) != 0);
      r = (rx_occ > 0) && ($urandom_range(0, 1) == 1);
      s = v && (m_cred != 0);
      cycle(v, r, $urandom);
      rx_occ = rx_occ + (s ? 1 : 0) - (r ? 1 : 0);
      check("rx_no_overflow", 32'(DEPTH - 32'(o_credits)), 32'(rx_occ));
    end

    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/pt_credit_tx.md
PT_CREDIT_TX -- requirements
Module: pt_credit_tx

Interface
REQ-001 SHALL have parameter DATA_T, default logic [31:0], type of one transferred item.
REQ-002 SHALL have parameter DEPTH, default 8, remote receive-buffer capacity in entries (initial credit count, >= 1).
REQ-003 SHALL derive localparam COUNT_W = $clog2(DEPTH+1), width of credit count.
REQ-004 SHALL have one clock; reset is synchronous and active-low.
REQ-005 i_clk  input  1  clock; all state updates on rising edge.
REQ-006 i_rst  input  1  synchronous active-low reset.
REQ-007 i_data  input  DATA_T  upstream item.
REQ-008 i_valid  input  1  upstream item valid.
REQ-009 o_ready  output  1  upstream may transfer this cycle.
REQ-010 o_tx_data  output  DATA_T  registered item to remote receiver.
REQ-011 o_tx_valid  output  1  registered one-cycle strobe qualifying o_tx_data; no backpressure.
REQ-012 i_crd_return  input  1  one credit returned by remote receiver on pop, one per cycle max.
REQ-013 o_credits  output  COUNT_W  current credit count.
REQ-014 o_state  output  2  FSM state: 0 FULL, 1 PARTIAL, 2 EMPTY.
REQ-015 o_idle  output  1  high when all DEPTH credits held (state FULL).
REQ-016 o_error  output  1  sticky credit-overflow flag (see Configuration).

Function
REQ-017 SHALL define send = i_valid && o_ready; o_ready = (credits_q != 0), driven only from registered state.
REQ-018 SHALL update credits_q <= credits_q - send + i_crd_return each cycle, COUNT_W arithmetic.
REQ-019 Simultaneous send and return SHALL leave credits_q unchanged.
REQ-020 Return arriving at credits_q == 0 SHALL NOT allow a send that cycle; o_ready rises the following cycle.
REQ-021 Return at credits_q == DEPTH without send SHALL be dropped; credits_q saturates at DEPTH.
REQ-022 On send, o_tx_data SHALL register i_data and o_tx_valid SHALL be high next cycle (latency 1); else o_tx_valid low, o_tx_data holds last value.
REQ-023 FSM next state from next credit value: DEPTH -> FULL, 0 -> EMPTY, otherwise PARTIAL; DEPTH==1 never enters PARTIAL.
REQ-024 Legal transitions: FULL->PARTIAL/EMPTY, PARTIAL->FULL/EMPTY/PARTIAL, EMPTY->PARTIAL/FULL; any other change is an assertion failure.
REQ-025 o_credits SHALL equal credits_q; o_idle SHALL equal (o_state == FULL).

Reset
REQ-026 While i_rst low at rising edge: credits_q = DEPTH, state FULL, o_tx_valid = 0, o_tx_data = 0, o_error = 0.
REQ-027 i_crd_return and i_valid during reset SHALL be ignored; reset mid-operation discards in-flight accounting.
REQ-028 First send permitted in first cycle after i_rst returns high.

Configuration
REQ-029 Macro PT_CREDIT_TX_CHECK_EN defined: return at credits_q == DEPTH without send SHALL set o_error high until reset.
REQ-030 PT_CREDIT_TX_CHECK_EN undefined: o_error tied 0, excess return silently dropped per REQ-021, no extra flops.

Verification (DEPTH=4)
REQ-031 Reset, i_valid held high, no returns -> 4 sends on consecutive cycles, o_tx_valid 4 cycles from cycle+1, credits 4->0, state FULL->PARTIAL->EMPTY, o_ready low.
REQ-032 At credits 0, assert i_crd_return one cycle with i_valid high -> no send that cycle, credits 1, o_ready high next cycle, send follows.
REQ-033 At credits 2, send and return same cycle -> credits stay 2, state PARTIAL, o_tx_valid next cycle.
REQ-034 At FULL, pulse i_crd_return -> credits stay 4; o_error 1 with PT_CREDIT_TX_CHECK_EN, 0 without.
REQ-035 At credits 1 with o_error set, drive i_rst low one cycle -> credits 4, FULL, o_idle 1, o_tx_valid 0, o_error 0.
REQ-036 Random i_valid/i_crd_return against model FIFO of depth 4 -> never overflows, o_tx_data order matches i_data order.
